ahb_lite_regbank: RTL and testbench
===================================

Name: ahb_lite_regbank

Overview:
- Parametrised AHB-Lite slave register bank; successor to the fixed UART-style register file.
- Configurable data width, RW/RO register counts, wait-state insertion and privileged-only mode.
- Proper two-cycle ERROR response and native HSIZE/HADDR byte-lane decode (no side-band strobe).
- Sits behind the AHB decoder; drives peripheral control registers and samples status inputs.

Parameters:
- DATA_W, 32: bus width; legal values 32 or 64. NB = DATA_W/8 byte lanes; OFS = log2(NB).
- NUM_RW, 6: read/write registers, word offsets 0..NUM_RW-1.
- NUM_RO, 3: read-only registers, word offsets NUM_RW..NUM_RW+NUM_RO-1.
- WAIT_STATES, 0: extra HREADYOUT-low cycles per OKAY data phase; legal range 0..7.
- PRIV_ONLY, 0: when 1, a user access (HPROT[1]=0) is an error.

Ports:
- HCLK  in  1  clock
- HRESETn  in  1  asynchronous active-low reset
- HSEL  in  1  slave select
- HADDR  in  12  byte address (bank-relative)
- HTRANS  in  2  IDLE/BUSY/NONSEQ/SEQ
- HWRITE  in  1  1 = write
- HSIZE  in  3  transfer size
- HPROT  in  4  protection; bit 1 = privileged
- HWDATA  in  DATA_W  write data (data phase)
- HREADY  in  1  bus ready (from mux)
- HREADYOUT  out  1  slave ready
- HRESP  out  1  0 = OKAY, 1 = ERROR
- HRDATA  out  DATA_W  read data
- rw_regs_o  out  NUM_RW*DATA_W  RW register contents, register k at slice k
- ro_regs_i  in  NUM_RO*DATA_W  RO register values, register j at slice j
- wr_pulse_o  out  NUM_RW  1-cycle pulse per RW register written
- rd_pulse_o  out  NUM_RO  1-cycle pulse per RO register read (read-to-clear hook)

Behaviour:
- Reset (asynchronous): rw_regs_o = 0; HREADYOUT = 1; HRESP = 0; HRDATA = 0; pulses = 0; FSM = IDLE.
- Reset asserted mid-transfer aborts it with no register update.
- Address phase accepted when HSEL & HREADY & HTRANS[1]. On acceptance, capture HADDR, HWRITE, HSIZE and error status.
- IDLE/BUSY transfers, or HSEL = 0: no capture; the next data phase is a zero-wait OKAY.
- Error if any of the following holds:
  - word index HADDR[11:OFS] >= NUM_RW+NUM_RO;
  - HSIZE > OFS;
  - unaligned access (HADDR bits below 2^HSIZE are nonzero);
  - write to an RO register;
  - PRIV_ONLY & !HPROT[1].
- FSM states: IDLE, WAIT, ERR1, ERR2.
  - IDLE: on an accepted, error-free transfer with WAIT_STATES > 0, go to WAIT and load counter = WAIT_STATES.
  - IDLE: on an accepted, error-free transfer with WAIT_STATES = 0, stay in IDLE; the data phase completes next cycle with HREADYOUT = 1.
  - IDLE: on an accepted transfer with an error, go to ERR1.
  - WAIT: HREADYOUT = 0; decrement the counter; at 0, drive HREADYOUT = 1 (completion cycle), then return to IDLE or accept a new transfer.
  - ERR1: HREADYOUT = 0, HRESP = 1.
  - ERR2: HREADYOUT = 1, HRESP = 1; may accept a new address phase in the same cycle.
- Writes commit at the rising edge ending the completing data-phase cycle.
  - Byte lane b is written iff b lies in [addr[OFS-1:0], addr[OFS-1:0] + 2^HSIZE - 1].
  - The matching wr_pulse_o bit is high for the cycle after the commit.
- Reads: HRDATA is combinational from the captured index during the data phase, and 0 otherwise or on error.
  - The full word is returned; the master selects lanes.
  - The rd_pulse_o bit fires for one cycle after the completing cycle.
- Back-to-back write then read of the same register returns the newly written value, with no stall.
- Errored transfers never modify registers and never pulse.

Test Plan:
- DATA_W=32, WAIT_STATES=0: NONSEQ write 0xA5A5_1234 to 0x008, then NONSEQ read of 0x008 → write data phase OKAY with no wait; read returns 0xA5A5_1234; wr_pulse_o[2] high for 1 cycle.
- Byte write 0xEE to 0x005, then read 0x004 (register reset to 0) → returns 0x0000_EE00; other bytes unchanged.
- Write to RO address 0x018 (NUM_RW=6), and separately an unaligned word read at 0x002 → each gives HREADYOUT 0 then 1 with HRESP = 1 for both cycles; no pulse, registers unchanged.
- WAIT_STATES=3: a word read completes only after 3 cycles of HREADYOUT = 0; a pipelined following transfer holds its address until HREADY rises.
- PRIV_ONLY=1: write with HPROT = 0000 → ERROR; same write with HPROT = 0010 → OKAY and the register is updated.
- DATA_W=64: halfword write at 0x00E → only lanes 6–7 of register 1 change. Assert HRESETn low during a WAIT cycle → all outputs return to reset values immediately.

Source files
------------

// File: rtl/ahb_lite_regbank.sv
// AHB-Lite slave register bank: NUM_RW read/write words followed by NUM_RO read-only
// words, HSIZE/HADDR byte-lane writes, optional wait states and two-cycle ERROR response.
module ahb_lite_regbank #(
    parameter int DATA_W      = 32,
    parameter int NUM_RW      = 6,
    parameter int NUM_RO      = 3,
    parameter int WAIT_STATES = 0,
    parameter int PRIV_ONLY   = 0
) (
    input  logic                       HCLK,
    input  logic                       HRESETn,
    input  logic                       HSEL,
    input  logic [11:0]                HADDR,
    input  logic [1:0]                 HTRANS,
    input  logic                       HWRITE,
    input  logic [2:0]                 HSIZE,
    input  logic [3:0]                 HPROT,
    input  logic [DATA_W-1:0]          HWDATA,
    input  logic                       HREADY,
    output logic                       HREADYOUT,
    output logic                       HRESP,
    output logic [DATA_W-1:0]          HRDATA,
    output logic [NUM_RW*DATA_W-1:0]   rw_regs_o,
    input  logic [NUM_RO*DATA_W-1:0]   ro_regs_i,
    output logic [NUM_RW-1:0]          wr_pulse_o,
    output logic [NUM_RO-1:0]          rd_pulse_o
);
    localparam int NB       = DATA_W / 8;
    localparam int OFS      = $clog2(NB);
    localparam int IDX_W    = 12 - OFS;
    localparam int NUM_REGS = NUM_RW + NUM_RO;

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ERR1, ST_ERR2} state_t;

    state_t            state;
    logic [2:0]        wait_cnt;
    logic              hready_q;
    logic              hresp_q;
    logic              dp_valid;
    logic              dp_write;
    logic [IDX_W-1:0]  dp_idx;
    logic [NB-1:0]     dp_be;

    logic              accept;
    logic              a_err;
    logic              free;
    logic              commit;
    logic              rd_done;
    logic [IDX_W-1:0]  a_idx;
    logic [OFS-1:0]    a_lane;
    logic [OFS-1:0]    a_mask;
    logic [NB-1:0]     a_be;
    logic [NUM_REGS-1:0]                dp_sel;
    logic [NUM_REGS-1:0][DATA_W-1:0]    rd_src;
    logic [DATA_W-1:0][NUM_REGS-1:0]    rd_col;
    logic [DATA_W-1:0]                  rd_word;
    logic              unused_ok;

    assign unused_ok = ^{HTRANS[0], HPROT};

    // Address-phase decode; only meaningful while accept is high.
    assign accept = HSEL & HREADY & HTRANS[1];
    assign a_idx  = HADDR[11:OFS];
    assign a_lane = HADDR[OFS-1:0];
    assign a_mask = OFS'((32'd1 << HSIZE) - 32'd1);
    assign a_be   = NB'(((32'd1 << (32'd1 << HSIZE)) - 32'd1) << a_lane);

    always_comb begin
        a_err = 1'b0;
        if (32'(a_idx) >= NUM_REGS)               a_err = 1'b1;
        if (int'(HSIZE) > OFS)                    a_err = 1'b1;
        if ((a_lane & a_mask) != '0)              a_err = 1'b1;
        if (HWRITE && (32'(a_idx) >= NUM_RW))     a_err = 1'b1;
        if ((PRIV_ONLY != 0) && !HPROT[1])        a_err = 1'b1;
    end

    // Cycles in which HREADYOUT is high and a new address phase may be taken.
    assign free    = (state == ST_IDLE) || (state == ST_ERR2) ||
                     ((state == ST_WAIT) && (wait_cnt == 3'd0));
    assign commit  = dp_valid & hready_q & dp_write;
    assign rd_done = dp_valid & hready_q & ~dp_write;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state    <= ST_IDLE;
            wait_cnt <= 3'd0;
            hready_q <= 1'b1;
            hresp_q  <= 1'b0;
            dp_valid <= 1'b0;
            dp_write <= 1'b0;
            dp_idx   <= '0;
            dp_be    <= '0;
        end else if (free) begin
            if (accept) begin
                dp_write <= HWRITE;
                dp_idx   <= a_idx;
                dp_be    <= a_be;
                if (a_err) begin
                    state    <= ST_ERR1;
                    hready_q <= 1'b0;
                    hresp_q  <= 1'b1;
                    dp_valid <= 1'b0;
                end else if (WAIT_STATES > 0) begin
                    state    <= ST_WAIT;
                    wait_cnt <= 3'(WAIT_STATES);
                    hready_q <= 1'b0;
                    hresp_q  <= 1'b0;
                    dp_valid <= 1'b1;
                end else begin
                    state    <= ST_IDLE;
                    hready_q <= 1'b1;
                    hresp_q  <= 1'b0;
                    dp_valid <= 1'b1;
                end
            end else begin
                state    <= ST_IDLE;
                hready_q <= 1'b1;
                hresp_q  <= 1'b0;
                dp_valid <= 1'b0;
            end
        end else if (state == ST_ERR1) begin
            state    <= ST_ERR2;
            hready_q <= 1'b1;
            hresp_q  <= 1'b1;
        end else begin
            wait_cnt <= wait_cnt - 3'd1;
            if (wait_cnt == 3'd1) hready_q <= 1'b1;
        end
    end

    assign HREADYOUT = hready_q;
    assign HRESP     = hresp_q;

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_sel
        assign dp_sel[g] = (dp_idx == IDX_W'(g));
    end

    for (genvar k = 0; k < NUM_RW; k++) begin : g_rw
        for (genvar b = 0; b < NB; b++) begin : g_byte
            logic [7:0] byte_q;
            always_ff @(posedge HCLK or negedge HRESETn) begin
                if (!HRESETn)                            byte_q <= '0;
                else if (commit && dp_sel[k] && dp_be[b]) byte_q <= HWDATA[8*b +: 8];
            end
            assign rw_regs_o[k*DATA_W + 8*b +: 8] = byte_q;
        end
        logic pulse_q;
        always_ff @(posedge HCLK or negedge HRESETn) begin
            if (!HRESETn) pulse_q <= 1'b0;
            else          pulse_q <= commit & dp_sel[k];
        end
        assign wr_pulse_o[k] = pulse_q;
        assign rd_src[k]     = rw_regs_o[k*DATA_W +: DATA_W];
    end

    for (genvar j = 0; j < NUM_RO; j++) begin : g_ro
        logic pulse_q;
        always_ff @(posedge HCLK or negedge HRESETn) begin
            if (!HRESETn) pulse_q <= 1'b0;
            else          pulse_q <= rd_done & dp_sel[NUM_RW+j];
        end
        assign rd_pulse_o[j]       = pulse_q;
        assign rd_src[NUM_RW + j]  = ro_regs_i[j*DATA_W +: DATA_W];
    end

    // One-hot AND-OR read mux over all registers.
    for (genvar bb = 0; bb < DATA_W; bb++) begin : g_rbit
        for (genvar g = 0; g < NUM_REGS; g++) begin : g_rrow
            assign rd_col[bb][g] = dp_sel[g] & rd_src[g][bb];
        end
        assign rd_word[bb] = |rd_col[bb];
    end

    assign HRDATA = (dp_valid && !dp_write) ? rd_word : '0;

endmodule

// File: tb/tb_ahb_lite_regbank.sv
// Bench for ahb_lite_regbank: a 32-bit zero-wait bank and a 64-bit privileged bank with
// three wait states share one AHB-Lite bus; a scoreboard checks every data phase.
module tb_ahb_lite_regbank;
    logic          HCLK = 1'b0;
    logic          HRESETn;
    logic          HSEL_a, HSEL_b;
    logic [11:0]   HADDR;
    logic [1:0]    HTRANS;
    logic          HWRITE;
    logic [2:0]    HSIZE;
    logic [3:0]    HPROT;
    logic [63:0]   HWDATA;

    logic          HREADYOUT_a, HRESP_a;
    logic [31:0]   HRDATA_a;
    logic [191:0]  rw_regs_a;
    logic [95:0]   ro_regs_a;
    logic [5:0]    wr_pulse_a;
    logic [2:0]    rd_pulse_a;

    logic          HREADYOUT_b, HRESP_b;
    logic [63:0]   HRDATA_b;
    logic [383:0]  rw_regs_b;
    logic [191:0]  ro_regs_b;
    logic [5:0]    wr_pulse_b;
    logic [2:0]    rd_pulse_b;

    logic          bus_ready, bus_resp;
    logic [63:0]   bus_rdata;

    assign bus_ready = HREADYOUT_a & HREADYOUT_b;
    assign bus_resp  = HRESP_a | HRESP_b;
    assign bus_rdata = {32'h0, HRDATA_a} | HRDATA_b;
    assign ro_regs_a = {32'hC0DE0003, 32'hC0DE0002, 32'hC0DE0001};
    assign ro_regs_b = {64'hF00D000000000003, 64'hF00D000000000002, 64'hF00D000000000001};

    always #5 HCLK = ~HCLK;

    ahb_lite_regbank #(.DATA_W(32), .NUM_RW(6), .NUM_RO(3), .WAIT_STATES(0), .PRIV_ONLY(0)) u_a (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL_a), .HADDR(HADDR), .HTRANS(HTRANS),
        .HWRITE(HWRITE), .HSIZE(HSIZE), .HPROT(HPROT), .HWDATA(HWDATA[31:0]), .HREADY(bus_ready),
        .HREADYOUT(HREADYOUT_a), .HRESP(HRESP_a), .HRDATA(HRDATA_a), .rw_regs_o(rw_regs_a),
        .ro_regs_i(ro_regs_a), .wr_pulse_o(wr_pulse_a), .rd_pulse_o(rd_pulse_a));

    ahb_lite_regbank #(.DATA_W(64), .NUM_RW(6), .NUM_RO(3), .WAIT_STATES(3), .PRIV_ONLY(1)) u_b (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL_b), .HADDR(HADDR), .HTRANS(HTRANS),
        .HWRITE(HWRITE), .HSIZE(HSIZE), .HPROT(HPROT), .HWDATA(HWDATA), .HREADY(bus_ready),
        .HREADYOUT(HREADYOUT_b), .HRESP(HRESP_b), .HRDATA(HRDATA_b), .rw_regs_o(rw_regs_b),
        .ro_regs_i(ro_regs_b), .wr_pulse_o(wr_pulse_b), .rd_pulse_o(rd_pulse_b));

    // Scoreboard: one entry per issued transfer, retired when its data phase completes.
    logic [63:0] exp_q[$];
    logic        err_q[$];
    int          wait_q[$];

    int          checks = 0;
    int          failures = 0;

    logic        ap_valid = 1'b0;
    logic [63:0] ap_wdata;
    logic        ap_err;
    string       ap_tag;
    logic        dp_pending = 1'b0;
    logic        dp_err = 1'b0;
    string       dp_tag = "";
    int          dp_waits = 0;

    localparam logic [3:0] P_USER = 4'b0000;
    localparam logic [3:0] P_PRIV = 4'b0010;
    localparam logic [3:0] P_DATA = 4'b0001;

    task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic bus_idle();
        HSEL_a = 1'b0; HSEL_b = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0;
        HADDR = 12'h0; HSIZE = 3'd0; HPROT = P_DATA;
    endtask

    // One bus clock: retire/observe the data phase at negedge, advance the pipeline after posedge.
    task automatic clk_cycle();
        logic        rdy;
        logic [63:0] e_data;
        logic        e_err;
        int          e_wait;
        @(negedge HCLK);
        rdy = bus_ready;
        if (dp_pending) begin
            if (!rdy) begin
                dp_waits++;
                if (dp_err) chk($sformatf("%s_err1_resp", dp_tag), 192'(bus_resp), 192'(1'b1));
            end else begin
                e_data = exp_q.pop_front();
                e_err  = err_q.pop_front();
                e_wait = wait_q.pop_front();
                chk($sformatf("%s_rdata", dp_tag), 192'(bus_rdata), 192'(e_data));
                chk($sformatf("%s_resp", dp_tag), 192'(bus_resp), 192'(e_err));
                chk($sformatf("%s_waits", dp_tag), 192'(dp_waits), 192'(e_wait));
                dp_pending = 1'b0;
            end
        end
        @(posedge HCLK);
        #1;
        if (rdy && ap_valid) begin
            dp_pending = 1'b1;
            dp_waits   = 0;
            dp_err     = ap_err;
            dp_tag     = ap_tag;
            HWDATA     = ap_wdata;
            ap_valid   = 1'b0;
            bus_idle();
        end
    endtask

    task automatic issue(input string tag, input bit to_b, input bit wr, input logic [11:0] addr,
                         input logic [2:0] size, input logic [3:0] prot, input logic [63:0] wdata,
                         input logic [63:0] exp, input bit err);
        int n;
        HSEL_a = !to_b; HSEL_b = to_b; HADDR = addr; HTRANS = 2'b10;
        HWRITE = wr; HSIZE = size; HPROT = prot;
        ap_valid = 1'b1; ap_wdata = wdata; ap_err = err; ap_tag = tag;
        exp_q.push_back(exp);
        err_q.push_back(err);
        wait_q.push_back(err ? 1 : (to_b ? 3 : 0));
        n = 0;
        while (ap_valid && n < 20) begin
            clk_cycle();
            n++;
        end
        chk($sformatf("%s_accepted", tag), 192'(ap_valid), 192'(1'b0));
        if (ap_valid) begin
            ap_valid = 1'b0;
            bus_idle();
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (dp_pending && n < 20) begin
            clk_cycle();
            n++;
        end
        chk("drain_done", 192'(dp_pending), 192'(1'b0));
        dp_pending = 1'b0;
    endtask

    initial begin
        HRESETn = 1'b0;
        HWDATA  = 64'h0;
        bus_idle();
        repeat (3) @(posedge HCLK);
        #1;
        chk("rst_hready_a", 192'(HREADYOUT_a), 192'(1'b1));
        chk("rst_hresp_a",  192'(HRESP_a),     192'(1'b0));
        chk("rst_hrdata_a", 192'(HRDATA_a),    192'(0));
        chk("rst_rw_a",     rw_regs_a,         192'(0));
        chk("rst_wrp_a",    192'(wr_pulse_a),  192'(0));
        chk("rst_rdp_a",    192'(rd_pulse_a),  192'(0));
        chk("rst_hready_b", 192'(HREADYOUT_b), 192'(1'b1));
        chk("rst_hrdata_b", 192'(HRDATA_b),    192'(0));
        @(negedge HCLK);
        HRESETn = 1'b1;
        @(posedge HCLK);
        #1;

        // 32-bit bank: word write then back-to-back read
        issue("a_wr_w2", 0, 1, 12'h008, 3'd2, P_DATA, 64'hA5A51234, 64'h0, 0);
        issue("a_rd_w2", 0, 0, 12'h008, 3'd2, P_DATA, 64'h0, 64'hA5A51234, 0);
        chk("a_wr_pulse", 192'(wr_pulse_a), 192'(6'b000100));
        chk("a_reg2", 192'(rw_regs_a[64 +: 32]), 192'(32'hA5A51234));
        drain();
        chk("a_wr_pulse_clr", 192'(wr_pulse_a), 192'(0));

        // byte and halfword lane writes; other lanes carry junk that must be ignored
        issue("a_wr_b5",  0, 1, 12'h005, 3'd0, P_DATA, 64'hDDDDEEDD, 64'h0, 0);
        issue("a_rd_w1",  0, 0, 12'h004, 3'd2, P_DATA, 64'h0, 64'h0000EE00, 0);
        issue("a_wr_h6",  0, 1, 12'h006, 3'd1, P_DATA, 64'hBEEF7777, 64'h0, 0);
        issue("a_rd_w1b", 0, 0, 12'h004, 3'd2, P_DATA, 64'h0, 64'hBEEFEE00, 0);
        drain();

        // error cases
        issue("a_wr_ro", 0, 1, 12'h018, 3'd2, P_DATA, 64'hFFFFFFFF, 64'h0, 1);
        drain();
        chk("a_ro_wr_nopulse", 192'(wr_pulse_a), 192'(0));
        issue("a_rd_unal", 0, 0, 12'h002, 3'd2, P_DATA, 64'h0, 64'h0, 1);
        issue("a_rd_oor",  0, 0, 12'h024, 3'd2, P_DATA, 64'h0, 64'h0, 1);
        issue("a_rd_big",  0, 0, 12'h008, 3'd3, P_DATA, 64'h0, 64'h0, 1);
        drain();
        chk("a_err_nordp", 192'(rd_pulse_a), 192'(0));
        chk("a_regs_after_err", rw_regs_a,
            {32'h0, 32'h0, 32'h0, 32'hA5A51234, 32'hBEEFEE00, 32'h0});

        // read-only register read and its pulse
        issue("a_rd_ro1", 0, 0, 12'h01C, 3'd2, P_DATA, 64'h0, 64'hC0DE0002, 0);
        drain();
        chk("a_rd_pulse", 192'(rd_pulse_a), 192'(3'b010));

        // 64-bit privileged bank with wait states
        issue("b_wr_user", 1, 1, 12'h008, 3'd3, P_USER, 64'h1122334455667788, 64'h0, 1);
        drain();
        chk("b_user_noupd", 192'(rw_regs_b[64 +: 64]), 192'(0));
        chk("b_user_nopulse", 192'(wr_pulse_b), 192'(0));
        issue("b_wr_priv", 1, 1, 12'h008, 3'd3, P_PRIV, 64'h1122334455667788, 64'h0, 0);
        issue("b_rd_w1",   1, 0, 12'h008, 3'd3, P_PRIV, 64'h0, 64'h1122334455667788, 0);
        chk("b_wr_pulse", 192'(wr_pulse_b), 192'(6'b000010));
        issue("b_wr_h14",  1, 1, 12'h00E, 3'd1, P_PRIV, 64'hABCD999999999999, 64'h0, 0);
        issue("b_rd_w1b",  1, 0, 12'h008, 3'd3, P_PRIV, 64'h0, 64'hABCD334455667788, 0);
        drain();
        chk("b_reg1", 192'(rw_regs_b[64 +: 64]), 192'(64'hABCD334455667788));
        issue("b_rd_ro2", 1, 0, 12'h040, 3'd3, P_PRIV, 64'h0, 64'hF00D000000000003, 0);
        drain();
        chk("b_rd_pulse", 192'(rd_pulse_b), 192'(3'b100));

        // asynchronous reset in the middle of a wait-stated read
        issue("b_rd_rst", 1, 0, 12'h008, 3'd3, P_PRIV, 64'h0, 64'hABCD334455667788, 0);
        chk("b_in_wait", 192'(HREADYOUT_b), 192'(1'b0));
        HRESETn = 1'b0;
        #1;
        chk("mid_rst_hready_b", 192'(HREADYOUT_b), 192'(1'b1));
        chk("mid_rst_hresp_b",  192'(HRESP_b),     192'(1'b0));
        chk("mid_rst_hrdata_b", 192'(HRDATA_b),    192'(0));
        chk("mid_rst_rw_b",     192'(|rw_regs_b),  192'(1'b0));
        chk("mid_rst_rw_a",     192'(|rw_regs_a),  192'(1'b0));
        dp_pending = 1'b0;
        ap_valid   = 1'b0;
        exp_q.delete();
        err_q.delete();
        wait_q.delete();
        bus_idle();
        @(negedge HCLK);
        HRESETn = 1'b1;
        @(posedge HCLK);
        #1;
        issue("a_rd_post", 0, 0, 12'h008, 3'd2, P_DATA, 64'h0, 64'h0, 0);
        issue("b_rd_post", 1, 0, 12'h008, 3'd3, P_PRIV, 64'h0, 64'h0, 0);
        drain();
        chk("post_rst_nopulse", 192'(wr_pulse_b), 192'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
